// File: rtl/bg_fade_sequencer.sv
// -----------------------------------------------------------------------------
// bg_fade_sequencer
//
// Sequences background-level changes for the background mapper path. A request
// from the game FSM fades the active background out one brightness step per
// FRAMES_PER_STEP frame ticks, swaps the background select during vertical
// blank, then fades the new background back in.
//
// Ports:
//   vga_clk                     pixel clock (only clock)
//   Reset                       synchronous, active-high reset
//   DrawX, DrawY                current pixel column / row
//   blank                       high = active video
//   req_valid, req_sel          level-change request and requested background
//   req_ready                   request can be accepted (high only in IDLE)
//   bg_sel                      registered select for the external mapper mux
//   busy                        transition in progress (= !req_ready)
//   done                        one-cycle pulse when a request completes
//   in_red/in_green/in_blue     selected mapper RGB
//   red/green/blue              faded RGB, registered (1-cycle latency)
//
// Handshake: a request transfers on a rising vga_clk edge where
// req_valid && req_ready are both high. The requester must hold req_valid and
// req_sel stable until that edge; req_ready never depends on req_valid.
// -----------------------------------------------------------------------------
module bg_fade_sequencer #(
   parameter int NUM_BG          = 4,
   parameter int SEL_W           = 2,
   parameter int RESET_SEL       = 0,
   parameter int FRAMES_PER_STEP = 2,
   parameter int V_ACTIVE        = 480
) (
   input  logic             vga_clk,
   input  logic             Reset,
   input  logic [9:0]       DrawX,
   input  logic [9:0]       DrawY,
   input  logic             blank,
   input  logic             req_valid,
   input  logic [SEL_W-1:0] req_sel,
   output logic             req_ready,
   output logic [SEL_W-1:0] bg_sel,
   output logic             busy,
   output logic             done,
   input  logic [3:0]       in_red,
   input  logic [3:0]       in_green,
   input  logic [3:0]       in_blue,
   output logic [3:0]       red,
   output logic [3:0]       green,
   output logic [3:0]       blue
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_FADE_OUT = 2'd1;
   localparam logic [1:0] S_SWAP     = 2'd2;
   localparam logic [1:0] S_FADE_IN  = 2'd3;

   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   logic [1:0]       state;
   logic [4:0]       bright;    // 0..16, 16 = full brightness
   logic [CNT_W-1:0] frame_cnt;
   logic [SEL_W-1:0] pend_sel;

   logic frame_tick;
   logic accept;
   logic noop_req;
   logic step_due;

   // One pixel clock per frame: first column of the first blanked line.
   assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

   assign req_ready = (state == S_IDLE);
   assign busy      = ~req_ready;
   assign accept    = req_valid && req_ready;
   assign noop_req  = (req_sel == bg_sel) || (32'(req_sel) >= 32'(NUM_BG));
   assign step_due  = frame_tick && (frame_cnt == CNT_LAST);

   // Sequencer state
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         bright    <= 5'd16;
         frame_cnt <= '0;
         bg_sel    <= SEL_W'(RESET_SEL);
         pend_sel  <= SEL_W'(RESET_SEL);
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // A frame tick coinciding with the accept is deliberately not
               // counted: the counter is simply cleared here.
               if (accept) begin
                  pend_sel  <= req_sel;
                  frame_cnt <= '0;
                  if (noop_req) begin
                     done <= 1'b1;
                  end else begin
                     state <= S_FADE_OUT;
                  end
               end
            end
            S_FADE_OUT: begin
               if (frame_tick) begin
                  if (step_due) begin
                     frame_cnt <= '0;
                     bright    <= bright - 5'd1;
                     if (bright == 5'd1) begin
                        state <= S_SWAP;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            S_SWAP: begin
               // Reached right after a frame tick, i.e. inside vertical blank.
               bg_sel    <= pend_sel;
               frame_cnt <= '0;
               state     <= S_FADE_IN;
            end
            default: begin // S_FADE_IN
               if (frame_tick) begin
                  if (step_due) begin
                     frame_cnt <= '0;
                     bright    <= bright + 5'd1;
                     if (bright == 5'd15) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Colour scaling: (in * bright) >> 4 keeps product bits [7:4]; bright=16
   // reproduces the input exactly.
   logic [8:0] prod_r, prod_g, prod_b;

   assign prod_r = 9'(in_red)   * 9'(bright);
   assign prod_g = 9'(in_green) * 9'(bright);
   assign prod_b = 9'(in_blue)  * 9'(bright);

   always_ff @(posedge vga_clk) begin
      if (Reset || !blank) begin
         red   <= 4'd0;
         green <= 4'd0;
         blue  <= 4'd0;
      end else begin
         red   <= prod_r[7:4];
         green <= prod_g[7:4];
         blue  <= prod_b[7:4];
      end
   end

endmodule

// File: tb/tb_bg_fade_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for bg_fade_sequencer. DrawX/DrawY are driven directly so a
// frame tick costs one cycle instead of a whole VGA frame. With in_red=0xF and
// blank=1, red one cycle later equals (15*bright)>>4, which exposes the
// brightness level: 16->15, 15->14, 9->8, 8->7, 1->0, 0->0.
// NUM_BG=3 so that req_sel=3 is an out-of-range (no-op) request.
// -----------------------------------------------------------------------------
module tb_bg_fade_sequencer;

   localparam int SEL_W    = 2;
   localparam int V_ACTIVE = 480;

   logic             vga_clk = 1'b0;
   logic             Reset;
   logic [9:0]       DrawX, DrawY;
   logic             blank;
   logic             req_valid;
   logic [SEL_W-1:0] req_sel;
   logic             req_ready;
   logic [SEL_W-1:0] bg_sel;
   logic             busy;
   logic             done;
   logic [3:0]       in_red, in_green, in_blue;
   logic [3:0]       red, green, blue;

   int checks = 0;
   int errors = 0;

   // Clock / reset
   always #5 vga_clk = ~vga_clk;

   bg_fade_sequencer #(
      .NUM_BG(3), .SEL_W(SEL_W), .RESET_SEL(0),
      .FRAMES_PER_STEP(2), .V_ACTIVE(V_ACTIVE)
   ) dut (
      .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .bg_sel(bg_sel), .busy(busy), .done(done),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .red(red), .green(green), .blue(blue)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: optionally present a frame tick, sample 1 time unit after edge.
   task automatic clk_step(input bit tick);
      DrawX = tick ? 10'd0 : 10'd100;
      DrawY = tick ? 10'(V_ACTIVE) : 10'd100;
      @(posedge vga_clk);
      #1;
      DrawX = 10'd100;
      DrawY = 10'd100;
   endtask

   // n frame ticks (each followed by a quiet cycle) with the transition busy.
   task automatic do_ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         clk_step(1'b1);
         chk({tag, "_ready_low"}, 16'(req_ready), 16'd0);
         chk({tag, "_no_done"}, 16'(done), 16'd0);
         clk_step(1'b0);
      end
   endtask

   initial begin
      Reset = 1'b1; req_valid = 1'b0; req_sel = '0; blank = 1'b1;
      in_red = 4'hF; in_green = 4'hF; in_blue = 4'hF;
      DrawX = 10'd100; DrawY = 10'd100;

      // Power-on reset
      clk_step(1'b0); clk_step(1'b0);
      chk("rst_ready", 16'(req_ready), 16'd1);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_bg_sel", 16'(bg_sel), 16'd0);
      chk("rst_red", 16'(red), 16'd0);
      Reset = 1'b0;
      clk_step(1'b0);
      chk("rst_bright16", 16'(red), 16'd15);

      // Full transition 0 -> 2, request accepted on a frame-tick cycle
      req_valid = 1'b1; req_sel = 2'd2;
      clk_step(1'b1);
      req_valid = 1'b0;
      chk("acc_ready", 16'(req_ready), 16'd0);
      chk("acc_busy", 16'(busy), 16'd1);
      clk_step(1'b1); clk_step(1'b0);
      chk("tick1_bright16", 16'(red), 16'd15);
      clk_step(1'b1); clk_step(1'b0);
      chk("tick2_bright15", 16'(red), 16'd14);
      do_ticks(29, "fo");
      chk("fo_bright1", 16'(red), 16'd0);
      chk("fo_bg_sel_old", 16'(bg_sel), 16'd0);
      clk_step(1'b1);                       // bright -> 0, enter SWAP
      chk("fo_last_ready", 16'(req_ready), 16'd0);
      chk("pre_swap_bg_sel", 16'(bg_sel), 16'd0);
      clk_step(1'b0);                       // SWAP
      chk("swap_bg_sel", 16'(bg_sel), 16'd2);
      chk("swap_red0", 16'(red), 16'd0);
      do_ticks(16, "fi");                   // bright = 8

      // Colour scaling at bright = 8
      in_red = 4'hF; in_green = 4'h8; in_blue = 4'h1;
      clk_step(1'b0);
      chk("scale_red", 16'(red), 16'd7);
      chk("scale_green", 16'(green), 16'd4);
      chk("scale_blue", 16'(blue), 16'd0);
      blank = 1'b0;
      clk_step(1'b0);
      chk("blank_red", 16'(red), 16'd0);
      chk("blank_green", 16'(green), 16'd0);
      chk("blank_blue", 16'(blue), 16'd0);
      blank = 1'b1; in_green = 4'hF; in_blue = 4'hF;

      do_ticks(15, "fi2");                  // bright = 15
      clk_step(1'b1);                       // bright -> 16
      chk("fin_done", 16'(done), 16'd1);
      chk("fin_ready", 16'(req_ready), 16'd1);
      chk("fin_busy", 16'(busy), 16'd0);
      clk_step(1'b0);
      chk("fin_done_once", 16'(done), 16'd0);
      chk("fin_bright16", 16'(red), 16'd15);
      chk("fin_bg_sel", 16'(bg_sel), 16'd2);

      // Reset mid fade-out at bright = 9
      req_valid = 1'b1; req_sel = 2'd1;
      clk_step(1'b0);
      req_valid = 1'b0;
      do_ticks(14, "mid");
      chk("mid_bright9", 16'(red), 16'd8);
      Reset = 1'b1;
      clk_step(1'b0); clk_step(1'b0);
      Reset = 1'b0;
      chk("mrst_ready", 16'(req_ready), 16'd1);
      chk("mrst_busy", 16'(busy), 16'd0);
      chk("mrst_done", 16'(done), 16'd0);
      chk("mrst_bg_sel", 16'(bg_sel), 16'd0);
      chk("mrst_red", 16'(red), 16'd0);
      clk_step(1'b0);
      chk("mrst_bright16", 16'(red), 16'd15);

      // Full transition 0 -> 1
      req_valid = 1'b1; req_sel = 2'd1;
      clk_step(1'b0);
      req_valid = 1'b0;
      do_ticks(63, "t01");
      clk_step(1'b1);
      chk("t01_done", 16'(done), 16'd1);
      clk_step(1'b0);
      chk("t01_bg_sel", 16'(bg_sel), 16'd1);

      // No-op: req_sel == bg_sel, then req_sel out of range
      req_valid = 1'b1; req_sel = 2'd1;
      clk_step(1'b0);
      req_valid = 1'b0;
      chk("noop_same_done", 16'(done), 16'd1);
      chk("noop_same_busy", 16'(busy), 16'd0);
      clk_step(1'b0);
      chk("noop_same_done_once", 16'(done), 16'd0);
      chk("noop_same_busy2", 16'(busy), 16'd0);
      chk("noop_same_bright", 16'(red), 16'd15);
      req_valid = 1'b1; req_sel = 2'd3;
      clk_step(1'b0);
      req_valid = 1'b0;
      chk("noop_range_done", 16'(done), 16'd1);
      chk("noop_range_busy", 16'(busy), 16'd0);
      clk_step(1'b0);
      chk("noop_range_done_once", 16'(done), 16'd0);
      chk("noop_range_busy2", 16'(busy), 16'd0);
      chk("noop_range_bright", 16'(red), 16'd15);
      chk("noop_range_bg_sel", 16'(bg_sel), 16'd1);

      // Backpressure: request 3 held through a 1 -> 0 transition
      req_valid = 1'b1; req_sel = 2'd0;
      clk_step(1'b0);
      req_sel = 2'd3;
      do_ticks(63, "bp");
      clk_step(1'b1);
      chk("bp_fin_done", 16'(done), 16'd1);
      chk("bp_fin_ready", 16'(req_ready), 16'd1);
      chk("bp_fin_bg_sel", 16'(bg_sel), 16'd0);
      clk_step(1'b0);                       // held request accepted here
      req_valid = 1'b0;
      chk("bp_acc_done", 16'(done), 16'd1);
      chk("bp_acc_busy", 16'(busy), 16'd0);
      chk("bp_acc_bg_sel", 16'(bg_sel), 16'd0);
      clk_step(1'b0);
      chk("bp_done_clear", 16'(done), 16'd0);
      chk("bp_ready", 16'(req_ready), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bg_fade_sequencer.md
Name: bg_fade_sequencer

Overview:
Sequences background-level changes for the background mapper path. It accepts a level-change request from the game FSM and fades the active background out over a fixed number of frames. During vertical blank it switches the background select, then fades the new background back in. It sits between the background mapper RGB outputs (muxed externally by bg_sel) and the VGA output.

Parameters:
NUM_BG, 4, number of selectable backgrounds
SEL_W, 2, width of the background select
RESET_SEL, 0, bg_sel value after reset
FRAMES_PER_STEP, 2, frame ticks per brightness step (>=1)
V_ACTIVE, 480, first DrawY line of vertical blank

Ports:
vga_clk  in  1  pixel clock; only clock
Reset  in  1  synchronous, active-high reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  high = active video (same polarity as the mappers)
req_valid  in  1  level-change request
req_sel  in  SEL_W  requested background
req_ready  out  1  request can be accepted
bg_sel  out  SEL_W  drives the external mapper mux
busy  out  1  transition in progress
done  out  1  one-cycle pulse when a request completes
in_red/in_green/in_blue  in  4 each  selected mapper RGB
red/green/blue  out  4 each  faded RGB to VGA

Behaviour:
- Reset (synchronous, active-high; also when asserted mid-transition):
  - state=IDLE, bright=16, frame counter=0, bg_sel=RESET_SEL, pending select=RESET_SEL.
  - red/green/blue=0, done=0, busy=0.
  - req_ready=1 from the first cycle after reset.
- frame_tick is high for exactly one cycle when DrawX==0 && DrawY==V_ACTIVE.
- req_ready = (state==IDLE). busy = !req_ready.
- Accept condition: req_valid && req_ready.
  - The pending select is latched from req_sel.
  - The frame counter is cleared.
  - A frame_tick in the accept cycle is not counted.
- No-op accept: if req_sel==bg_sel or req_sel>=NUM_BG, the request is accepted.
  - bg_sel is unchanged, state stays IDLE.
  - done pulses in the next cycle; no fade occurs.
- Requests while busy are not accepted. The requester must hold req_valid and req_sel until it sees req_ready.
- States: IDLE -> FADE_OUT -> SWAP -> FADE_IN -> IDLE.
  - FADE_OUT, on each frame_tick:
    - If counter==FRAMES_PER_STEP-1: counter=0 and bright decrements; otherwise counter increments.
    - On the tick where bright becomes 0, next state is SWAP.
  - SWAP lasts one cycle. bg_sel <= pending select; counter=0; next state FADE_IN.
  - FADE_IN mirrors FADE_OUT but increments bright. On the tick where bright becomes 16, next state is IDLE and done=1 for the following single cycle.
- bright changes only on frame_tick, so there is no mid-frame tearing.
- A full transition takes 32*FRAMES_PER_STEP frame ticks.
- Colour arithmetic, per channel:
  - out = (in * bright) >> 4, where in is 4b, bright is 5b (0..16), product is 9b; keep bits [7:4].
  - bright=16 gives out=in exactly; bright=0 gives 0.
- Output is registered with 1-cycle latency from in_* and blank, matching the mapper pipeline.
  - When blank==0, red/green/blue <= 0.
- bg_sel is registered and changes only in SWAP, which falls inside vertical blank.

Test Plan:
- Reset: assert Reset for 2 cycles mid-FADE_OUT (bright=9) -> next cycle bright=16, bg_sel=0, req_ready=1, RGB=0, done=0.
- Full transition, FRAMES_PER_STEP=2, bg_sel=0, req_sel=2:
  - Accept -> after 32 ticks bright=0, SWAP sets bg_sel=2.
  - After 32 more ticks bright=16 and done pulses once.
  - req_ready stays low throughout.
- Colour scaling: in_red=0xF, in_green=0x8, in_blue=0x1 with bright=8 and blank=1 -> one cycle later red=7, green=4, blue=0. With blank=0 -> all 0.
- No-op: req_sel=bg_sel=1 -> accepted, done pulses next cycle, bright stays 16, busy never high. Repeat with req_sel=3 under NUM_BG=3 -> same response.
- Backpressure: req_valid held with req_sel=3 during a transition -> not accepted until IDLE, then accepted on the first cycle req_ready=1.
- Tick in accept cycle: assert req_valid on a frame_tick cycle -> that tick is not counted; bright first drops at the 2nd following tick.
